// File: rtl/rf_read_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port_arb_if
// Description : Request/grant/feedback bundle between the issue queues
//               (master) and the regfile read-port arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_read_port_arb_if #(
  parameter int IQ_NUM     = 3,
  parameter int IQ_PORT    = 2,
  parameter int RDPORT_NUM = 4,
  parameter int NUMSRCS    = 2,
  parameter int PRF_IDXW   = 7
);
  localparam int c_req_num = IQ_NUM * IQ_PORT;

  logic                                   i_flush;
  logic [c_req_num-1:0]                   i_req_vld;
  logic [c_req_num*NUMSRCS-1:0]           i_req_src_need;
  logic [c_req_num*NUMSRCS*PRF_IDXW-1:0]  i_req_src_idx;
  logic [c_req_num-1:0]                   o_grant;
  logic [RDPORT_NUM-1:0]                  o_rf_ren;
  logic [RDPORT_NUM*PRF_IDXW-1:0]         o_rf_raddr;
  logic [c_req_num-1:0]                   o_deq_vld;
  logic [c_req_num-1:0]                   o_replay_vld;

  // Issue-queue side: presents requests, consumes grants and feedback.
  modport master (
    output i_flush, i_req_vld, i_req_src_need, i_req_src_idx,
    input  o_grant, o_rf_ren, o_rf_raddr, o_deq_vld, o_replay_vld
  );

  // Arbiter side.
  modport slave (
    input  i_flush, i_req_vld, i_req_src_need, i_req_src_idx,
    output o_grant, o_rf_ren, o_rf_raddr, o_deq_vld, o_replay_vld
  );
endinterface
`default_nettype wire

// File: rtl/rf_read_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port_arb
// Description : All-or-nothing allocation of shared integer-regfile read
//               ports among issue ports. Urgent (starved) requesters are
//               served first in ascending index, then the rest round-robin
//               from rr_ptr; a requester that does not fit is skipped.
//               Grants are combinational; deq/replay feedback is registered.
//               Optional macro RF_ARB_DEDUP_EN: sources reading an index that
//               is already bound this cycle share that port at no cost.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port_arb #(
  parameter int IQ_NUM       = 3,
  parameter int IQ_PORT      = 2,
  parameter int RDPORT_NUM   = 4,
  parameter int NUMSRCS      = 2,
  parameter int PRF_IDXW     = 7,
  parameter int STARVE_LIMIT = 7
) (
  input  wire logic          clk,
  input  wire logic          rst,
  rf_read_port_arb_if.slave  bus
);
  localparam int c_req_num = IQ_NUM * IQ_PORT;
  localparam int c_rrw     = (c_req_num > 1) ? $clog2(c_req_num) : 1;

  logic [c_rrw-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [c_req_num-1:0][3:0]          starve_q, starve_d;
  logic [c_req_num-1:0]               deq_q, deq_d;
  logic [c_req_num-1:0]               replay_q, replay_d;

  logic [c_req_num-1:0]               w_urgent;
  logic [c_req_num-1:0]               w_grant;
  logic [RDPORT_NUM-1:0]              w_ren;
  logic [RDPORT_NUM-1:0][PRF_IDXW-1:0] w_raddr;
  logic                               w_any_nu;
  int                                 w_last_nu;
  logic                               w_kill;

  assign w_kill = rst | bus.i_flush;

  // A requester becomes urgent once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_urgent = '0;
    for (int r = 0; r < c_req_num; r++) begin
      w_urgent[r] = (starve_q[r] >= 4'(STARVE_LIMIT));
    end
  end

  // Two-pass allocation: pass 1 visits urgent requesters by index, pass 2
  // walks non-urgent ones circularly from rr_ptr. Ports bind lowest-first.
  always_comb begin
    int   used;
    int   cost;
    int   r;
    logic pass1;
    logic cand;
    logic dup;
    logic [PRF_IDXW-1:0] idx;

    w_grant   = '0;
    w_ren     = '0;
    w_raddr   = '0;
    w_any_nu  = 1'b0;
    w_last_nu = 0;
    used      = 0;
    cost      = 0;
    r         = 0;
    pass1     = 1'b0;
    cand      = 1'b0;
    dup       = 1'b0;
    idx       = '0;

    for (int k = 0; k < 2 * c_req_num; k++) begin
      pass1 = (k < c_req_num);
      r     = pass1 ? k : ((int'(rr_ptr_q) + k - c_req_num) % c_req_num);
      cand  = bus.i_req_vld[r] && (w_urgent[r] == pass1);

      // Cost: ports this requester would newly occupy.
      cost = 0;
      for (int s = 0; s < NUMSRCS; s++) begin
        if (bus.i_req_src_need[r*NUMSRCS+s]) begin
          idx = bus.i_req_src_idx[(r*NUMSRCS+s)*PRF_IDXW +: PRF_IDXW];
          dup = 1'b0;
`ifdef RF_ARB_DEDUP_EN
          for (int p = 0; p < RDPORT_NUM; p++) begin
            if (w_ren[p] && (w_raddr[p] == idx)) dup = 1'b1;
          end
          for (int s2 = 0; s2 < NUMSRCS; s2++) begin
            if ((s2 < s) && bus.i_req_src_need[r*NUMSRCS+s2] &&
                (bus.i_req_src_idx[(r*NUMSRCS+s2)*PRF_IDXW +: PRF_IDXW] == idx))
              dup = 1'b1;
          end
`endif
          if (!dup) cost = cost + 1;
        end
      end

      if (cand && (cost <= RDPORT_NUM - used)) begin
        w_grant[r] = 1'b1;
        if (!pass1) begin
          w_any_nu  = 1'b1;
          w_last_nu = r;
        end
        // Bind needed sources in s order to the next free ports.
        for (int s = 0; s < NUMSRCS; s++) begin
          if (bus.i_req_src_need[r*NUMSRCS+s]) begin
            idx = bus.i_req_src_idx[(r*NUMSRCS+s)*PRF_IDXW +: PRF_IDXW];
            dup = 1'b0;
`ifdef RF_ARB_DEDUP_EN
            for (int p = 0; p < RDPORT_NUM; p++) begin
              if (w_ren[p] && (w_raddr[p] == idx)) dup = 1'b1;
            end
`endif
            if (!dup) begin
              for (int p = 0; p < RDPORT_NUM; p++) begin
                if (p == used) begin
                  w_ren[p]   = 1'b1;
                  w_raddr[p] = idx;
                end
              end
              used = used + 1;
            end
          end
        end
      end
    end
  end

  assign bus.o_grant      = w_kill ? '0 : w_grant;
  assign bus.o_rf_ren     = w_kill ? '0 : w_ren;
  assign bus.o_rf_raddr   = w_kill ? '0 : w_raddr;
  assign bus.o_deq_vld    = deq_q;
  assign bus.o_replay_vld = replay_q;

  // Next state: feedback, starvation counters and round-robin pointer.
  always_comb begin
    deq_d    = bus.i_req_vld & w_grant;
    replay_d = bus.i_req_vld & ~w_grant;
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    if (w_any_nu) rr_ptr_d = c_rrw'((w_last_nu + 1) % c_req_num);
    for (int r = 0; r < c_req_num; r++) begin
      if (!bus.i_req_vld[r] || w_grant[r]) starve_d[r] = 4'd0;
      else if (starve_q[r] != 4'hF)        starve_d[r] = starve_q[r] + 4'd1;
    end
    if (bus.i_flush) begin
      deq_d    = '0;
      replay_d = '0;
      starve_d = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      starve_q <= '0;
      deq_q    <= '0;
      replay_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      deq_q    <= deq_d;
      replay_q <= replay_d;
    end
  end
endmodule
`default_nettype wire
